// File: rtl/mac_merge.sv
// mac_merge: merges per-core neuron accumulators into lanes of G cores each.
// Each lane collects its selected members, then presents a saturated sum until it is accepted.
module mac_merge #(
    parameter int NUM_CORE   = 4,
    parameter int NUM_NEURON = 128,
    parameter int ACC_W      = 13,
    parameter int OUT_W      = 13
) (
    input  logic                                clk_in,
    input  logic                                rstb,
    input  logic [NUM_CORE-1:0]                 select,
    input  logic [1:0]                          comb_mode,
    input  logic [NUM_CORE-1:0]                 core_valid,
    input  logic [NUM_CORE*NUM_NEURON*ACC_W-1:0] core_accum,
    input  logic [NUM_CORE-1:0]                 out_ready,
    output logic [NUM_CORE-1:0]                 out_valid,
    output logic [NUM_CORE*NUM_NEURON*OUT_W-1:0] out_data,
    output logic [NUM_CORE-1:0]                 sat_flag,
    output logic [NUM_CORE-1:0]                 overrun,
    output logic                                busy
);

    // state     | meaning
    // S_IDLE    | lane empty; the first member delivery loads the accumulator
    // S_COLLECT | some members delivered, waiting for the remaining ones
    // S_OUT     | saturated result presented, held until out_ready

    localparam int LG_NC   = $clog2(NUM_CORE);
    localparam int SW      = ACC_W + LG_NC;
    localparam int LANE_AW = NUM_NEURON * SW;
    localparam int LANE_OW = NUM_NEURON * OUT_W;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_OUT     = 2'd2
    } state_t;

    state_t                               r_state [NUM_CORE];
    logic [NUM_CORE*LANE_AW-1:0]          r_acc;
    logic [NUM_CORE*LANE_OW-1:0]          r_out_data;
    logic [NUM_CORE-1:0]                  r_got;
    logic [NUM_CORE-1:0]                  r_cfg_sel;
    logic [1:0]                           r_cfg_lg;
    logic [NUM_CORE-1:0]                  r_out_valid;
    logic [NUM_CORE-1:0]                  r_sat;
    logic [NUM_CORE-1:0]                  r_overrun;

    logic                                 w_busy;
    logic [1:0]                           w_mode_lg;
    logic [1:0]                           w_lg;
    logic [NUM_CORE-1:0]                  w_sel;
    logic [LG_NC-1:0]                     w_lmask;
    logic [LG_NC-1:0]                     w_lane [NUM_CORE];
    logic [NUM_CORE-1:0]                  w_mem  [NUM_CORE];
    logic [NUM_CORE-1:0]                  w_take;
    logic [NUM_CORE-1:0]                  w_ovr_set;
    logic [NUM_CORE-1:0]                  w_done;
    logic [NUM_CORE-1:0]                  w_hs;
    logic [NUM_CORE*LANE_AW-1:0]          w_acc_nxt;
    logic [NUM_CORE*LANE_OW-1:0]          w_clamp;
    logic [NUM_CORE-1:0]                  w_sat;

    function automatic logic signed [SW-1:0] f_sext(input logic [ACC_W-1:0] x);
        return {{(SW-ACC_W){x[ACC_W-1]}}, x};
    endfunction

    // Returns {clamped, value}; in range when the bits above OUT_W-1 are all sign copies.
    function automatic logic [OUT_W:0] f_clamp(input logic signed [SW-1:0] v);
        if ((&v[SW-1:OUT_W-1]) || !(|v[SW-1:OUT_W-1]))
            return {1'b0, v[OUT_W-1:0]};
        else if (v[SW-1])
            return {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
        else
            return {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
    endfunction

    always_comb begin
        w_busy = 1'b0;
        for (int l = 0; l < NUM_CORE; l++)
            if (r_state[l] != S_IDLE) w_busy = 1'b1;
    end

    always_comb begin
        case (comb_mode)
            2'd1:    w_mode_lg = 2'd1;
            2'd2:    w_mode_lg = 2'd2;
            default: w_mode_lg = 2'd0;
        endcase
        if (int'(w_mode_lg) > LG_NC) w_mode_lg = 2'(LG_NC);
    end

    // Live inputs steer idle cycles; the registered copy holds while any lane is busy.
    assign w_lg    = w_busy ? r_cfg_lg  : w_mode_lg;
    assign w_sel   = w_busy ? r_cfg_sel : select;
    assign w_lmask = LG_NC'((NUM_CORE >> w_lg) - 1);

    always_comb begin
        for (int c = 0; c < NUM_CORE; c++)
            w_lane[c] = LG_NC'(c) & w_lmask;
    end

    always_comb begin
        for (int l = 0; l < NUM_CORE; l++) begin
            w_mem[l] = '0;
            for (int c = 0; c < NUM_CORE; c++)
                w_mem[l][c] = w_sel[c] && (w_lane[c] == LG_NC'(l));
        end
    end

    always_comb begin
        w_take    = '0;
        w_ovr_set = '0;
        for (int c = 0; c < NUM_CORE; c++) begin
            w_take[c]    = core_valid[c] && w_sel[c] && !r_got[c]
                           && (r_state[w_lane[c]] != S_OUT);
            w_ovr_set[c] = core_valid[c] && w_sel[c]
                           && (r_got[c] || (r_state[w_lane[c]] == S_OUT));
        end
    end

    always_comb begin
        w_done = '0;
        w_hs   = '0;
        for (int l = 0; l < NUM_CORE; l++) begin
            w_done[l] = (w_mem[l] != '0) && (|(w_take & w_mem[l]))
                        && (((r_got | w_take) & w_mem[l]) == w_mem[l]);
            w_hs[l]   = (r_state[l] == S_OUT) && out_ready[l];
        end
    end

    // Full-width signed sum per neuron; an idle lane starts from zero instead of its stale value.
    always_comb begin : p_sum
        logic signed [SW-1:0] v_s;
        logic [OUT_W:0]       v_c;
        v_s       = '0;
        v_c       = '0;
        w_acc_nxt = '0;
        w_clamp   = '0;
        w_sat     = '0;
        for (int l = 0; l < NUM_CORE; l++) begin
            for (int n = 0; n < NUM_NEURON; n++) begin
                v_s = (r_state[l] == S_IDLE) ? '0 : r_acc[(l*NUM_NEURON+n)*SW +: SW];
                for (int c = 0; c < NUM_CORE; c++)
                    if (w_take[c] && w_mem[l][c])
                        v_s = v_s + f_sext(core_accum[(c*NUM_NEURON+n)*ACC_W +: ACC_W]);
                w_acc_nxt[(l*NUM_NEURON+n)*SW +: SW] = v_s;
                v_c = f_clamp(v_s);
                w_clamp[(l*NUM_NEURON+n)*OUT_W +: OUT_W] = v_c[OUT_W-1:0];
                if (v_c[OUT_W]) w_sat[l] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rstb) begin
            for (int l = 0; l < NUM_CORE; l++) r_state[l] <= S_IDLE;
            r_acc       <= '0;
            r_out_data  <= '0;
            r_got       <= '0;
            r_cfg_sel   <= '0;
            r_cfg_lg    <= '0;
            r_out_valid <= '0;
            r_sat       <= '0;
            r_overrun   <= '0;
        end else begin
            if (!w_busy) begin
                r_cfg_sel <= select;
                r_cfg_lg  <= w_mode_lg;
            end
            r_overrun <= r_overrun | w_ovr_set;
            for (int c = 0; c < NUM_CORE; c++) begin
                if (w_take[c])
                    r_got[c] <= 1'b1;
                else if (w_hs[w_lane[c]])
                    r_got[c] <= 1'b0;
            end
            for (int l = 0; l < NUM_CORE; l++) begin
                case (r_state[l])
                    S_IDLE, S_COLLECT: begin
                        if (|(w_take & w_mem[l])) begin
                            r_acc[l*LANE_AW +: LANE_AW] <= w_acc_nxt[l*LANE_AW +: LANE_AW];
                            if (w_done[l]) begin
                                r_state[l]     <= S_OUT;
                                r_out_valid[l] <= 1'b1;
                                r_sat[l]       <= w_sat[l];
                                r_out_data[l*LANE_OW +: LANE_OW] <= w_clamp[l*LANE_OW +: LANE_OW];
                            end else begin
                                r_state[l] <= S_COLLECT;
                            end
                        end
                    end
                    S_OUT: begin
                        if (out_ready[l]) begin
                            r_state[l]     <= S_IDLE;
                            r_out_valid[l] <= 1'b0;
                            r_sat[l]       <= 1'b0;
                            r_acc[l*LANE_AW +: LANE_AW]      <= '0;
                            r_out_data[l*LANE_OW +: LANE_OW] <= '0;
                        end
                    end
                    default: r_state[l] <= S_IDLE;
                endcase
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign sat_flag  = r_sat;
    assign overrun   = r_overrun;
    assign busy      = w_busy;

endmodule

// File: tb/tb_mac_merge.sv
// tb_mac_merge: directed scenarios plus randomized transactions against an
// integer-sum model of lane grouping, completion and saturation.
module tb_mac_merge;

    localparam int NC = 4;
    localparam int NN = 128;
    localparam int AW = 13;
    localparam int OW = 13;
    localparam int LW = NN * OW;

    logic                 clk_in = 1'b0;
    logic                 rstb;
    logic [NC-1:0]        select;
    logic [1:0]           comb_mode;
    logic [NC-1:0]        core_valid;
    logic [NC*NN*AW-1:0]  core_accum;
    logic [NC-1:0]        out_ready;
    logic [NC-1:0]        out_valid;
    logic [NC*NN*OW-1:0]  out_data;
    logic [NC-1:0]        sat_flag;
    logic [NC-1:0]        overrun;
    logic                 busy;

    int total = 0;
    int bad   = 0;
    int m_acc [NC][NN];

    mac_merge #(.NUM_CORE(NC), .NUM_NEURON(NN), .ACC_W(AW), .OUT_W(OW)) dut (
        .clk_in    (clk_in),
        .rstb      (rstb),
        .select    (select),
        .comb_mode (comb_mode),
        .core_valid(core_valid),
        .core_accum(core_accum),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .sat_flag  (sat_flag),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_lane(input string tag, input int l, input logic [LW-1:0] exp);
        logic [LW-1:0]         o;
        logic signed [OW-1:0]  ov;
        logic signed [OW-1:0]  ev;
        int                    bn;
        o = out_data[l*LW +: LW];
        total++;
        assert (o === exp) else begin
            bad++;
            bn = 0;
            for (int n = NN-1; n >= 0; n--)
                if (o[n*OW +: OW] !== exp[n*OW +: OW]) bn = n;
            ov = o[bn*OW +: OW];
            ev = exp[bn*OW +: OW];
            $error("FAIL %s lane=%0d neuron=%0d observed=%0d expected=%0d", tag, l, bn, ov, ev);
        end
    endtask

    function automatic logic signed [31:0] od(input int l, input int n);
        logic signed [OW-1:0] t;
        t = out_data[(l*NN+n)*OW +: OW];
        return t;
    endfunction

    task automatic set_acc(input int c, input int n, input int v);
        core_accum[(c*NN+n)*AW +: AW] = AW'(v);
        m_acc[c][n] = v;
    endtask

    task automatic clr_acc();
        core_accum = '0;
        for (int c = 0; c < NC; c++)
            for (int n = 0; n < NN; n++) m_acc[c][n] = 0;
    endtask

    task automatic hs(input logic [NC-1:0] m);
        out_ready = m;
        tick();
        out_ready = '0;
    endtask

    // Reference model: group size from mode, core c -> lane c mod (NC/G).
    function automatic int g_log(input logic [1:0] mode);
        case (mode)
            2'd1:    return 1;
            2'd2:    return 2;
            default: return 0;
        endcase
    endfunction

    function automatic logic [NC-1:0] members(input logic [1:0] mode, input logic [NC-1:0] sel, input int l);
        logic [NC-1:0] m;
        int nl;
        nl = NC >> g_log(mode);
        m  = '0;
        for (int c = 0; c < NC; c++)
            if (sel[c] && ((c % nl) == l)) m[c] = 1'b1;
        return m;
    endfunction

    function automatic logic [NC-1:0] exp_valid(input logic [1:0] mode, input logic [NC-1:0] sel,
                                                input logic [NC-1:0] dlv);
        logic [NC-1:0] v;
        logic [NC-1:0] m;
        v = '0;
        for (int l = 0; l < NC; l++) begin
            m = members(mode, sel, l);
            if ((m != '0) && ((m & dlv) == m)) v[l] = 1'b1;
        end
        return v;
    endfunction

    function automatic int clampv(input int v);
        if (v > 4095) return 4095;
        if (v < -4096) return -4096;
        return v;
    endfunction

    function automatic int lane_sum(input logic [1:0] mode, input logic [NC-1:0] sel, input int l, input int n);
        logic [NC-1:0] m;
        int s;
        m = members(mode, sel, l);
        s = 0;
        for (int c = 0; c < NC; c++)
            if (m[c]) s += m_acc[c][n];
        return s;
    endfunction

    function automatic logic [LW-1:0] exp_data(input logic [1:0] mode, input logic [NC-1:0] sel, input int l);
        logic [LW-1:0] e;
        for (int n = 0; n < NN; n++) e[n*OW +: OW] = OW'(clampv(lane_sum(mode, sel, l, n)));
        return e;
    endfunction

    function automatic logic exp_sat(input logic [1:0] mode, input logic [NC-1:0] sel, input int l);
        int s;
        for (int n = 0; n < NN; n++) begin
            s = lane_sum(mode, sel, l, n);
            if (clampv(s) != s) return 1'b1;
        end
        return 1'b0;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]    mode;
        logic [NC-1:0] sel;
        logic [NC-1:0] dlv;
        logic [NC-1:0] ev;
        logic [NC-1:0] es;
        logic [NC-1:0] rdy;
        int            dt [NC];

        rstb = 1'b1; select = '0; comb_mode = '0; core_valid = '0; out_ready = '0;
        clr_acc();
        tick(); tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_sat", sat_flag, 0);
        chk("rst_data_nonzero", |out_data, 0);
        rstb = 1'b0;
        tick();

        // G=1, single core completes its own lane one cycle later
        comb_mode = 2'd0; select = 4'b1111; clr_acc(); set_acc(0, 5, 100);
        tick();
        core_valid = 4'b0001; tick(); core_valid = '0;
        chk("g1_valid", out_valid, 4'b0001);
        chk("g1_n5", od(0, 5), 100);
        chk_lane("g1_lane0", 0, exp_data(2'd0, 4'b1111, 0));
        chk("g1_other_lanes_zero", |out_data[NC*LW-1:LW], 0);
        chk("g1_busy", busy, 1);
        hs(4'b0001);
        chk("g1_after_hs_valid", out_valid, 0);
        chk("g1_after_hs_busy", busy, 0);

        // G=2, cores 0 and 2 three cycles apart, positive saturation
        comb_mode = 2'd1; select = 4'b0101; clr_acc(); set_acc(0, 0, 4000); set_acc(2, 0, 3000);
        tick();
        core_valid = 4'b0001; tick(); core_valid = '0;
        chk("g2_wait0_valid", out_valid, 0);
        chk("g2_wait0_busy", busy, 1);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("g2_wait_valid", out_valid, 0);
        end
        core_valid = 4'b0100; tick(); core_valid = '0;
        chk("g2_valid", out_valid, 4'b0001);
        chk("g2_n0_sat", od(0, 0), 4095);
        chk("g2_satflag", sat_flag, 4'b0001);
        chk_lane("g2_lane0", 0, exp_data(2'd1, 4'b0101, 0));
        hs(4'b0001);

        // G=4, all cores in one cycle, busy until handshake
        comb_mode = 2'd2; select = 4'b1111; clr_acc();
        set_acc(0, 7, -10); set_acc(1, 7, -20); set_acc(2, 7, 30); set_acc(3, 7, 5);
        tick();
        core_valid = 4'b1111; tick(); core_valid = '0;
        chk("g4_valid", out_valid, 4'b0001);
        chk("g4_n7", od(0, 7), 5);
        chk("g4_sat", sat_flag, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("g4_hold_busy", busy, 1);
            chk("g4_hold_valid", out_valid, 4'b0001);
        end
        hs(4'b0001);
        chk("g4_after_hs_busy", busy, 0);

        // G=2, stalled output while core 0 pulses again
        comb_mode = 2'd1; select = 4'b1111; clr_acc(); set_acc(0, 3, 111); set_acc(2, 3, -50);
        tick();
        core_valid = 4'b0101; tick(); core_valid = '0;
        chk("ovr_valid", out_valid, 4'b0001);
        chk("ovr_overrun_before", overrun, 0);
        set_acc(0, 3, 999);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) core_valid = 4'b0001;
            tick();
            core_valid = '0;
            chk("ovr_hold_n3", od(0, 3), 61);
            chk("ovr_hold_valid", out_valid, 4'b0001);
        end
        chk("ovr_overrun", overrun, 4'b0001);
        hs(4'b0001);
        for (int i = 0; i < 3; i++) begin
            chk("ovr_no_second_valid", out_valid, 0);
            chk("ovr_no_second_busy", busy, 0);
            tick();
        end

        // comb_mode changes mid-collect; old grouping finishes, new one applies after idle
        comb_mode = 2'd1; select = 4'b1111; clr_acc();
        set_acc(0, 0, 10); set_acc(1, 0, 20); set_acc(2, 0, 30); set_acc(3, 0, 40);
        tick();
        core_valid = 4'b0001; tick(); core_valid = '0;
        chk("cfg_busy", busy, 1);
        comb_mode = 2'd2;
        tick();
        core_valid = 4'b0100; tick(); core_valid = '0;
        chk("cfg_old_valid", out_valid, 4'b0001);
        chk("cfg_old_n0", od(0, 0), 40);
        hs(4'b1111);
        chk("cfg_idle", busy, 0);
        core_valid = 4'b0011; tick(); core_valid = '0;
        chk("cfg_new_partial", out_valid, 0);
        core_valid = 4'b1100; tick(); core_valid = '0;
        chk("cfg_new_valid", out_valid, 4'b0001);
        chk("cfg_new_n0", od(0, 0), 100);
        hs(4'b1111);

        // Reset during collect abandons the partial sum
        comb_mode = 2'd1; select = 4'b0101; clr_acc(); set_acc(0, 1, 500);
        tick();
        core_valid = 4'b0001; tick(); core_valid = '0;
        chk("rc_busy", busy, 1);
        rstb = 1'b1; tick(); rstb = 1'b0;
        chk("rc_valid", out_valid, 0);
        chk("rc_busy_clr", busy, 0);
        chk("rc_overrun_clr", overrun, 0);
        chk("rc_sat", sat_flag, 0);
        chk("rc_data_nonzero", |out_data, 0);
        comb_mode = 2'd0; select = 4'b0001; set_acc(0, 1, -7);
        core_valid = 4'b0001; tick(); core_valid = '0;
        chk("rc_fresh_valid", out_valid, 4'b0001);
        chk("rc_fresh_n1", od(0, 1), -7);
        hs(4'b0001);
        tick();

        // Randomized transactions
        for (int t = 0; t < 40; t++) begin
            mode = 2'($urandom_range(0, 3));
            sel  = NC'($urandom_range(0, 15));
            for (int c = 0; c < NC; c++)
                for (int n = 0; n < NN; n++)
                    set_acc(c, n, int'($urandom_range(0, 8191)) - 4096);
            for (int c = 0; c < NC; c++) begin
                if (sel[c]) dt[c] = int'($urandom_range(0, 3));
                else        dt[c] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : -1;
            end
            comb_mode = mode;
            select    = sel;
            dlv       = '0;
            for (int cyc = 0; cyc < 4; cyc++) begin
                core_valid = '0;
                for (int c = 0; c < NC; c++)
                    if (dt[c] == cyc) core_valid[c] = 1'b1;
                dlv = dlv | (core_valid & sel);
                tick();
                core_valid = '0;
                chk($sformatf("rnd%0d_valid_c%0d", t, cyc), out_valid, exp_valid(mode, sel, dlv));
            end
            ev = exp_valid(mode, sel, dlv);
            es = '0;
            for (int l = 0; l < NC; l++) begin
                if (ev[l]) begin
                    es[l] = exp_sat(mode, sel, l);
                    chk_lane($sformatf("rnd%0d_data", t), l, exp_data(mode, sel, l));
                end else begin
                    chk_lane($sformatf("rnd%0d_idle_data", t), l, '0);
                end
            end
            chk($sformatf("rnd%0d_sat", t), sat_flag, es);
            chk($sformatf("rnd%0d_overrun", t), overrun, 0);
            rdy = NC'($urandom_range(0, 15));
            hs(rdy);
            chk($sformatf("rnd%0d_partial_hs", t), out_valid, ev & ~rdy);
            hs(4'b1111);
            chk($sformatf("rnd%0d_idle", t), busy, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mac_merge.md
MAC_MERGE -- requirements
Module: mac_merge

Interface
REQ-001 The block SHALL have parameter NUM_CORE, default 4, giving the number of MAC cores merged; it is a power of 2 and at least 2.
REQ-002 The block SHALL have parameter NUM_NEURON, default 128, giving the neurons per core.
REQ-003 The block SHALL have parameter ACC_W, default 13, giving the signed per-core accumulator width.
REQ-004 The block SHALL have parameter OUT_W, default 13, giving the signed output width; OUT_W <= ACC_W+log2(NUM_CORE).
REQ-005 The block SHALL have port clk_in, input, 1 bit: the only clock.
REQ-006 The block SHALL have port rstb, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port select, input, NUM_CORE bits: core participates when 1.
REQ-008 The block SHALL have port comb_mode, input, 2 bits: group size G (0: G=1, 1: G=2, 2: G=4; 3: reserved, treated as 0).
REQ-009 The block SHALL have port core_valid, input, NUM_CORE bits: 1-cycle pulse per core, qualifying core_accum.
REQ-010 The block SHALL have port core_accum, input, NUM_CORE x NUM_NEURON x ACC_W bits: per-core neuron sums, signed.
REQ-011 The block SHALL have port out_ready, input, NUM_CORE bits: per-lane downstream accept.
REQ-012 The block SHALL have port out_valid, output, NUM_CORE bits: per-lane result valid.
REQ-013 The block SHALL have port out_data, output, NUM_CORE x NUM_NEURON x OUT_W bits: per-lane merged, saturated sums.
REQ-014 The block SHALL have port sat_flag, output, NUM_CORE bits: lane result contains at least one clamped neuron; meaningful only with out_valid.
REQ-015 The block SHALL have port overrun, output, NUM_CORE bits: sticky per core; a core_valid was dropped.
REQ-016 The block SHALL have port busy, output, 1 bit: some lane is not IDLE.

Function
REQ-017 The block SHALL assign core c to lane c mod (NUM_CORE/G); lanes >= NUM_CORE/G SHALL stay IDLE with out_valid=0; G > NUM_CORE SHALL be treated as G=NUM_CORE.
REQ-018 The block SHALL register comb_mode and select into an active configuration only in cycles where busy=0; changes while busy=1 SHALL take effect on the first cycle busy=0.
REQ-019 The block SHALL keep per lane: FSM {IDLE, COLLECT, OUT}, a NUM_NEURON x (ACC_W+log2 NUM_CORE) signed accumulator, and a got-mask of members delivered.
REQ-020 The block SHALL sum, in each cycle, core_accum of all member cores whose core_valid=1, are selected and not yet in got-mask, sign-extended, into the lane accumulator, with no per-neuron carry isolation loss.
REQ-021 On the first delivery the block SHALL move IDLE->COLLECT, or IDLE->OUT if that delivery completes the selected member set, with the accumulator loaded with the sum rather than added to the stale value.
REQ-022 The block SHALL move COLLECT->OUT in the cycle after the last selected member delivers.
REQ-023 out_valid SHALL be 1 exactly in OUT; latency SHALL be 1 cycle from the last member's core_valid to out_valid.
REQ-024 The block SHALL clamp each neuron of out_data to [-2^(OUT_W-1), 2^(OUT_W-1)-1], and sat_flag SHALL be the OR of clamp events of that lane.
REQ-025 out_data and sat_flag SHALL be held stable while out_valid=1 and out_ready=0.
REQ-026 On out_valid and out_ready both 1 the lane SHALL go to IDLE, clear the got-mask, and drop out_valid the next cycle.
REQ-027 core_valid from a core already in got-mask, or whose lane is in OUT, SHALL be ignored and set overrun[c].
REQ-028 core_valid from an unselected core SHALL be ignored without setting overrun.
REQ-029 A lane with no selected members SHALL never leave IDLE.
REQ-030 Delivery for a new result SHALL be accepted in the cycle after an OUT handshake (IDLE), not in the handshake cycle.
REQ-031 out_data SHALL be 0 for lanes not in OUT.

Reset
REQ-032 With rstb=1 at a clock edge, the block SHALL put all lanes in IDLE and clear accumulators, got-masks, out_valid, out_data, sat_flag, overrun and busy to 0, and set the active configuration to G=1 with no cores selected.
REQ-033 Reset asserted mid-COLLECT or mid-OUT SHALL abandon the partial result with no out_valid.

Verification
REQ-034 Bench SHALL cover: G=1, select=4'b1111, core_valid=4'b0001, core_accum[0][5]=100 -> next cycle out_valid[0]=1, out_data[0][5]=100, other lanes idle.
REQ-035 Bench SHALL cover: G=2, select=4'b0101, core 0 valid at t, core 2 valid at t+3 with neuron 0 = 4000 and 3000 -> out_valid[0] at t+4, out_data[0][0]=4095, sat_flag[0]=1.
REQ-036 Bench SHALL cover: G=4, all cores valid same cycle, neuron 7 = -10,-20,30,5 -> out_data[0][7]=5 one cycle later, busy=1 until handshake.
REQ-037 Bench SHALL cover: G=2, out_ready=0 for 5 cycles while core 0 pulses again -> data held, overrun[0]=1, no second result.
REQ-038 Bench SHALL cover: comb_mode changed from 1 to 2 while busy -> old grouping completes, new grouping used after busy=0.
REQ-039 Bench SHALL cover: rstb pulse during COLLECT -> all outputs 0 next cycle, a subsequent single delivery produces a fresh sum.
